// File: rtl/fa_lut_pkg.sv
// Shared constants, FSM encoding and the full-adder golden function for the
// LUT SRAM programmer.
package fa_lut_pkg;

  localparam int W      = 2;
  localparam int ADDR_W = 3 * W;
  localparam int DATA_W = W + 1;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // {Cout,S} for address {a,b,c}; the carry-out is whatever lands in bit W,
  // so the sum is simply taken modulo 2**DATA_W.
  function automatic logic [DATA_W-1:0] gold(input logic [ADDR_W-1:0] addr);
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic [W-1:0]      c;
    logic [DATA_W-1:0] sum;
    a   = addr[3*W-1:2*W];
    b   = addr[2*W-1:W];
    c   = addr[W-1:0];
    sum = DATA_W'(a) + DATA_W'(b) + DATA_W'(c);
    return sum;
  endfunction

endpackage

// File: rtl/fa_lut_golden.sv
// Combinational address -> {Cout,S} generator. One instance is shared between
// the write-data path and the read-back compare path.
module fa_lut_golden
  import fa_lut_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  assign data = gold(addr);

endmodule

// File: rtl/fulladder_sram_programmer.sv
// Fills the full-adder LUT SRAM with its truth table, reads every entry back
// through the synchronous read port and reports mismatches.
module fulladder_sram_programmer
  import fa_lut_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
  output logic [ADDR_W-1:0] err_addr,
  output logic              sram_we,
  output logic              sram_re,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  state_t              state;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W-1:0]   cnt_lo;
  logic [ADDR_W-1:0]   cnt_inc;
  logic                last_entry;
  logic                drain;

  logic                vld_p1;
  logic [ADDR_W-1:0]   addr_p1;

  logic [ADDR_W-1:0]   gen_addr;
  logic [DATA_W-1:0]   gen_data;
  logic                mismatch;
  logic [ADDR_W:0]     err_cnt_nxt;

  // cnt is one bit wider than the address so DEPTH-1 -> DEPTH is distinct
  assign cnt_lo     = cnt[ADDR_W-1:0];
  assign cnt_inc    = cnt_lo + ADDR_W'(1);
  assign last_entry = (cnt == (ADDR_W+1)'(DEPTH - 1));
  assign drain      = (cnt == (ADDR_W+1)'(DEPTH));

  // The generator serves the compare stage while a read result is pending,
  // otherwise it precomputes the next word to write (entry 0 from IDLE).
  always_comb begin
    gen_addr = '0;
    if (vld_p1) begin
      gen_addr = addr_p1;
    end else if (state == WRITE) begin
      gen_addr = cnt_inc;
    end
  end

  fa_lut_golden u_golden (
    .addr (gen_addr),
    .data (gen_data)
  );

  // Compare the returned word and build the saturating error count
  always_comb begin
    mismatch    = vld_p1 && (sram_rdata != gen_data);
    err_cnt_nxt = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_cnt_nxt = err_cnt + (ADDR_W+1)'(1);
    end
  end

  // --- stage p1: read data returns; valid follows the read strobe ---
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= sram_re;
    end
  end

  // Address tag travels with the read so the compare knows which entry returned
  always_ff @(posedge clk) begin
    if (sram_re) begin
      addr_p1 <= sram_addr;
    end
  end

  // Main sequencer: write sweep, read sweep plus drain, then a one-cycle done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      err_addr   <= '0;
      sram_we    <= 1'b0;
      sram_re    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= WRITE;
            busy       <= 1'b1;
            cnt        <= '0;
            err_cnt    <= '0;
            err_addr   <= '0;
            pass       <= 1'b0;
            sram_we    <= 1'b1;
            sram_addr  <= '0;
            sram_wdata <= gen_data;
          end
        end

        WRITE: begin
          if (last_entry) begin
            state      <= READ;
            cnt        <= '0;
            sram_we    <= 1'b0;
            sram_wdata <= '0;
            sram_re    <= 1'b1;
            sram_addr  <= '0;
          end else begin
            cnt        <= cnt + (ADDR_W+1)'(1);
            sram_addr  <= cnt_inc;
            sram_wdata <= gen_data;
          end
        end

        READ: begin
          err_cnt <= err_cnt_nxt;
          if (mismatch && (err_cnt == '0)) begin
            err_addr <= addr_p1;
          end
          if (drain) begin
            // last compare lands on this edge, so pass uses the updated count
            state <= DONE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_cnt_nxt == '0);
          end else if (last_entry) begin
            cnt       <= cnt + (ADDR_W+1)'(1);
            sram_re   <= 1'b0;
            sram_addr <= '0;
          end else begin
            cnt       <= cnt + (ADDR_W+1)'(1);
            sram_addr <= cnt_inc;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fulladder_sram_programmer.sv
// Bench for the LUT SRAM programmer: behavioural SRAM with fault injection,
// table-driven fault scenarios, randomized read-back corruption and
// hand-written start-while-busy and mid-run reset sequences.
module tb_fulladder_sram_programmer;

  localparam int AW    = 6;
  localparam int DW    = 3;
  localparam int NENT  = 64;
  localparam int DONE_EDGE = 2 * NENT + 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          pass;
  logic [AW:0]   err_cnt;
  logic [AW-1:0] err_addr;
  logic          sram_we;
  logic          sram_re;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata;

  int checks = 0;
  int errors = 0;

  fulladder_sram_programmer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_cnt    (err_cnt),
    .err_addr   (err_addr),
    .sram_we    (sram_we),
    .sram_re    (sram_re),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: write port plus synchronous read with injectable faults
  logic [DW-1:0] mem  [NENT];
  logic [DW-1:0] mask [NENT];
  bit            stuck0;

  function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = mem[a] ^ mask[a];
    if (stuck0) v[0] = 1'b0;
    return v;
  endfunction

  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= rd_val(sram_addr);
  end

  // Reference: the adder truth table from plain integer arithmetic
  function automatic int ref_gold(input int addr);
    int a, b, c;
    a = addr / 16;
    b = (addr / 4) % 4;
    c = addr % 4;
    return (a + b + c) % 8;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Protocol monitor, sampled on the falling edge
  int   v_we_re = 0;
  int   v_idle_bus = 0;
  int   v_done_wide = 0;
  int   v_err_mono = 0;
  logic prev_done = 1'b0;
  logic prev_busy = 1'b0;
  int   prev_err = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done <= 1'b0;
      prev_busy <= 1'b0;
      prev_err  <= 0;
    end else begin
      if (sram_we && sram_re) v_we_re <= v_we_re + 1;
      if (!sram_we && !sram_re && (sram_addr != 0 || sram_wdata != 0))
        v_idle_bus <= v_idle_bus + 1;
      if (done && prev_done) v_done_wide <= v_done_wide + 1;
      if (busy && prev_busy && int'(err_cnt) < prev_err) v_err_mono <= v_err_mono + 1;
      prev_done <= done;
      prev_busy <= busy;
      prev_err  <= int'(err_cnt);
    end
  end

  function automatic int all_outs();
    return int'({busy, done, pass, err_cnt, err_addr, sram_we, sram_re, sram_addr, sram_wdata});
  endfunction

  // Pulse start, then follow the run edge by edge until done (bounded)
  task automatic run_op(input bit inject, output int lat, output int ndone, output bit busy_ok);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    ndone = 0;
    busy_ok = 1'b1;
    for (int e = 1; e <= 400; e++) begin
      @(posedge clk);
      #1;
      if (done) begin
        ndone++;
        if (lat < 0) lat = e;
      end
      if (lat < 0 && e <= DONE_EDGE - 1 && !busy) busy_ok = 1'b0;
      if (inject && (e == 10 || e == 100)) start = 1'b1;
      else start = 1'b0;
      if (lat >= 0 && e >= lat + 5) break;
    end
    start = 1'b0;
  endtask

  function automatic int mem_mismatches();
    int n;
    n = 0;
    for (int k = 0; k < NENT; k++)
      if (int'(mem[k]) != ref_gold(k)) n++;
    return n;
  endfunction

  typedef struct {
    bit stuck;
    int bad_addr;
    int exp_pass;
    int exp_cnt;
    int exp_addr;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int  lat, ndone;
    bit  busy_ok;
    int  exp_cnt, exp_first;

    vecs[0] = '{stuck: 1'b0, bad_addr: -1, exp_pass: 1, exp_cnt: 0,  exp_addr: 0};
    vecs[1] = '{stuck: 1'b1, bad_addr: -1, exp_pass: 0, exp_cnt: 32, exp_addr: 1};
    vecs[2] = '{stuck: 1'b0, bad_addr: 45, exp_pass: 0, exp_cnt: 1,  exp_addr: 45};
    vecs[3] = '{stuck: 1'b0, bad_addr: 0,  exp_pass: 0, exp_cnt: 1,  exp_addr: 0};
    vecs[4] = '{stuck: 1'b0, bad_addr: 63, exp_pass: 0, exp_cnt: 1,  exp_addr: 63};

    stuck0 = 1'b0;
    for (int k = 0; k < NENT; k++) mask[k] = '0;
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Table-driven fault scenarios; the first also pulses start while busy
    for (int i = 0; i < 5; i++) begin
      stuck0 = vecs[i].stuck;
      for (int k = 0; k < NENT; k++) mask[k] = '0;
      if (vecs[i].bad_addr >= 0) mask[vecs[i].bad_addr] = 3'b100;
      run_op(i == 0, lat, ndone, busy_ok);
      check($sformatf("v%0d_done_edge", i), lat, DONE_EDGE);
      check($sformatf("v%0d_done_count", i), ndone, 1);
      check($sformatf("v%0d_busy_held", i), int'(busy_ok), 1);
      check($sformatf("v%0d_pass", i), int'(pass), vecs[i].exp_pass);
      check($sformatf("v%0d_err_cnt", i), int'(err_cnt), vecs[i].exp_cnt);
      check($sformatf("v%0d_err_addr", i), int'(err_addr), vecs[i].exp_addr);
      if (i == 0) begin
        check("mem_231", int'(mem[45]), 6);
        check("mem_333", int'(mem[63]), 1);
        check("mem_table", mem_mismatches(), 0);
      end
    end
    stuck0 = 1'b0;

    // Randomized read-back corruption against the reference model
    for (int r = 0; r < 4; r++) begin
      exp_cnt = 0;
      exp_first = -1;
      for (int k = 0; k < NENT; k++) begin
        mask[k] = '0;
        if ($urandom_range(0, 7) == 0) mask[k] = DW'($urandom_range(1, 7));
        if (mask[k] != 0) begin
          exp_cnt++;
          if (exp_first < 0) exp_first = k;
        end
      end
      run_op(1'b0, lat, ndone, busy_ok);
      check($sformatf("rnd%0d_done_edge", r), lat, DONE_EDGE);
      check($sformatf("rnd%0d_pass", r), int'(pass), (exp_cnt == 0) ? 1 : 0);
      check($sformatf("rnd%0d_err_cnt", r), int'(err_cnt), exp_cnt);
      check($sformatf("rnd%0d_err_addr", r), int'(err_addr), (exp_first < 0) ? 0 : exp_first);
    end
    for (int k = 0; k < NENT; k++) mask[k] = '0;

    // Reset in the middle of the read sweep, then a clean rerun
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (70) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check("midrun_reset_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 check("midrun_reset_hold", all_outs(), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, lat, ndone, busy_ok);
    check("rerun_done_edge", lat, DONE_EDGE);
    check("rerun_pass", int'(pass), 1);
    check("rerun_err_cnt", int'(err_cnt), 0);
    check("rerun_mem_table", mem_mismatches(), 0);

    check("we_re_overlap", v_we_re, 0);
    check("idle_bus_nonzero", v_idle_bus, 0);
    check("done_wider_than_one", v_done_wide, 0);
    check("err_cnt_decrease", v_err_mono, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
